// File: rtl/wd_store_ctrl.sv
// Store-cycle sequencer for the write-data register: replicates store data across lanes,
// loads wd_reg, drives the bus until memory stops waiting, and reports done/error.
module wd_store_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        st_req,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr,
  input  logic        mem_wait,
  output logic        st_ack,
  output logic        st_done,
  output logic        st_err,
  output logic        busy,
  output logic [31:0] WD_Bus_Write,
  output logic        WD_Load,
  output logic        WD_DBE,
  output logic [3:0]  byte_en,
  output logic        mem_wr
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRIVE, S_DONE, S_ERR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_ack;
  logic             accept;
  logic             illegal;
  logic             timeout;

  function automatic logic [31:0] rep_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   rep_data = {4{d[7:0]}};
      2'b01:   rep_data = {2{d[15:0]}};
      default: rep_data = d;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      2'b00:   lane_en = 4'b0001 << addr;
      2'b01:   lane_en = addr[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  endfunction

  // Requests are only sampled in IDLE and DONE; DONE accepts back-to-back without an IDLE cycle.
  assign accept  = st_req && ((state == S_IDLE) || (state == S_DONE));
  assign illegal = (st_size == 2'b11);
  assign timeout = mem_wait && (wait_cnt == CNT_W'(WAIT_MAX));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = illegal ? S_ERR : S_LOAD;
        else        state_nxt = S_IDLE;
      end
      S_LOAD:  state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (!mem_wait)    state_nxt = S_DONE;
        else if (timeout) state_nxt = S_ERR;
      end
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      err_ack      <= 1'b0;
      WD_Bus_Write <= '0;
      byte_en      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) err_ack <= illegal;
      if (accept && !illegal) begin
        WD_Bus_Write <= rep_data(st_size, st_data);
        byte_en      <= lane_en(st_size, st_addr);
      end
      if (state == S_LOAD)
        wait_cnt <= '0;
      else if ((state == S_DRIVE) && mem_wait && !timeout)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Strobes decode straight from state, so a reset releases the bus at the same edge.
  always_comb begin
    WD_Load = (state == S_LOAD);
    WD_DBE  = (state == S_DRIVE);
    mem_wr  = (state == S_DRIVE);
    st_done = (state == S_DONE);
    st_err  = (state == S_ERR);
    st_ack  = (state == S_LOAD) || ((state == S_ERR) && err_ack);
    busy    = (state != S_IDLE);
  end

endmodule

// File: tb/tb_wd_store_ctrl.sv
// Scoreboard bench for wd_store_ctrl: stimulus queues expected completions, a negedge monitor checks them.
module tb_wd_store_ctrl;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        st_req = 1'b0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic [1:0]  st_addr = '0;
  logic        mem_wait = 1'b0;
  logic        st_ack, st_done, st_err, busy, WD_Load, WD_DBE, mem_wr;
  logic [31:0] WD_Bus_Write;
  logic [3:0]  byte_en;

  wd_store_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut (
    .sysclk(sysclk), .reset(reset), .st_req(st_req), .st_data(st_data),
    .st_size(st_size), .st_addr(st_addr), .mem_wait(mem_wait),
    .st_ack(st_ack), .st_done(st_done), .st_err(st_err), .busy(busy),
    .WD_Bus_Write(WD_Bus_Write), .WD_Load(WD_Load), .WD_DBE(WD_DBE),
    .byte_en(byte_en), .mem_wr(mem_wr)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    logic [3:0]  be;
    int          drv;
    int          loads;
    logic        b2b;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int wait_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Memory model: holds mem_wait high for the first wait_req DRIVE cycles.
  initial begin
    int k = 0;
    forever begin
      @(negedge sysclk);
      if (WD_DBE) k++; else k = 0;
      mem_wait = WD_DBE && (k <= wait_req);
    end
  end

  // Monitor: observes each store and checks it against the scoreboard on st_done/st_err.
  initial begin
    int cyc = 0, drv = 0, loads = 0, acks = 0, load_cyc = -100, last_done = -100;
    logic [31:0] cap_data = '0;
    logic [3:0]  cap_be = '0;
    exp_t e;
    forever begin
      @(negedge sysclk);
      cyc++;
      if (reset) begin
        drv = 0; loads = 0; acks = 0; load_cyc = -100; last_done = -100;
      end else begin
        if (WD_DBE && WD_Load) chk("dbe_load_overlap", 1, 0);
        if (mem_wr !== WD_DBE) chk("mem_wr_eq_dbe", {31'b0, mem_wr}, {31'b0, WD_DBE});
        if (WD_Load) begin loads++; load_cyc = cyc; end
        if (st_ack) acks++;
        if (WD_DBE) begin
          if (drv == 0) begin cap_data = WD_Bus_Write; cap_be = byte_en; end
          drv++;
        end
        if (st_done || st_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_vs_err", {30'b0, st_err, st_done}, e.is_err ? 32'd2 : 32'd1);
            chk("drive_cycles", drv, e.drv);
            chk("load_pulses", loads, e.loads);
            chk("ack_pulses", acks, 1);
            if (e.drv > 0) begin
              chk("bus_data", cap_data, e.data);
              chk("byte_en", {28'b0, cap_be}, {28'b0, e.be});
              chk("load_to_end_latency", cyc - load_cyc, drv + 1);
              chk("back_to_back", (load_cyc == last_done + 1), e.b2b);
            end
          end
          if (st_done) last_done = cyc;
          drv = 0; loads = 0; acks = 0;
        end
      end
    end
  end

  function automatic exp_t mk(input logic is_err, input logic [31:0] data, input logic [3:0] be,
                              input int drv, input int loads, input logic b2b);
    exp_t e;
    e.is_err = is_err; e.data = data; e.be = be; e.drv = drv; e.loads = loads; e.b2b = b2b;
    return e;
  endfunction

  task automatic send(input logic [1:0] size, input logic [1:0] addr, input logic [31:0] data,
                      input int waits, input bit keep_req);
    bit got = 0;
    st_size = size; st_addr = addr; st_data = data; wait_req = waits; st_req = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge sysclk); #1;
      if (st_ack) got = 1;
    end
    if (!got) chk("ack_timeout", 0, 1);
    if (!keep_req) st_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(posedge sysclk); #1;
      if (!busy) idle = 1;
    end
    if (!idle) chk("idle_timeout", 0, 1);
    @(posedge sysclk); #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_outputs"}, {st_ack, st_done, st_err, busy, WD_Load, WD_DBE, mem_wr, byte_en}, 0);
    chk({tag, "_bus"}, WD_Bus_Write, 0);
  endtask

  initial begin
    repeat (2) @(posedge sysclk);
    #1 chk_quiet("reset");
    reset = 1'b0;
    @(posedge sysclk); #1;

    exp_q.push_back(mk(0, 32'h12345678, 4'b1111, 1, 1, 0));
    send(2'b10, 2'b01, 32'h12345678, 0, 0); wait_idle();
    exp_q.push_back(mk(0, 32'hA5A5A5A5, 4'b0100, 1, 1, 0));
    send(2'b00, 2'b10, 32'h000000A5, 0, 0); wait_idle();
    exp_q.push_back(mk(0, 32'hBEEFBEEF, 4'b1100, 1, 1, 0));
    send(2'b01, 2'b11, 32'h0000BEEF, 0, 0); wait_idle();
    exp_q.push_back(mk(0, 32'h12341234, 4'b0011, 1, 1, 0));
    send(2'b01, 2'b00, 32'hFFFF1234, 0, 0); wait_idle();
    exp_q.push_back(mk(0, 32'h5A5A5A5A, 4'b0001, 1, 1, 0));
    send(2'b00, 2'b00, 32'h1234565A, 0, 0); wait_idle();
    exp_q.push_back(mk(0, 32'hCAFEF00D, 4'b1111, 4, 1, 0));
    send(2'b10, 2'b00, 32'hCAFEF00D, 3, 0); wait_idle();
    exp_q.push_back(mk(1, 32'hDEADBEEF, 4'b1111, 16, 1, 0));
    send(2'b10, 2'b00, 32'hDEADBEEF, 1000, 0); wait_idle();
    exp_q.push_back(mk(1, 32'h0, 4'b0, 0, 0, 0));
    send(2'b11, 2'b00, 32'h11111111, 0, 0);
    chk("illegal_ack_with_err", {31'b0, st_err}, 1);
    wait_idle();

    exp_q.push_back(mk(0, 32'hAAAA5555, 4'b1111, 1, 1, 0));
    exp_q.push_back(mk(0, 32'h0F0F0F0F, 4'b1111, 1, 1, 1));
    send(2'b10, 2'b00, 32'hAAAA5555, 0, 1);
    send(2'b10, 2'b00, 32'h0F0F0F0F, 0, 0);
    wait_idle();

    send(2'b10, 2'b00, 32'h77777777, 1000, 0);
    @(posedge sysclk); #1;
    chk("drive_before_reset", {31'b0, WD_DBE}, 1);
    @(posedge sysclk); #1;
    reset = 1'b1;
    @(posedge sysclk); #1;
    chk_quiet("reset_mid_drive_1");
    @(posedge sysclk); #1;
    reset = 1'b0; wait_req = 0;
    chk_quiet("reset_mid_drive_2");
    @(posedge sysclk); #1;
    chk_quiet("after_reset");

    exp_q.push_back(mk(0, 32'h00990099, 4'b0011, 1, 1, 0));
    send(2'b01, 2'b01, 32'h00000099, 0, 0); wait_idle();

    repeat (3) @(posedge sysclk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
